// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage to a 4-byte-wide data memory.
// Handles one byte/half/word load or store per request. Loads are narrowed
// and sign/zero extended. Byte/half stores read-modify-write the memory word.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*  : request handshake (valid/ready, we, size, unsigned, addr, wdata)
//   resp_* : response handshake (valid/ready, rdata, err)
//   mem_*  : memory port (en, rw, addr, wdata out; rdata in, one cycle after read)
//
// Optional feature macro: ALIGN_CHECK_EN
//   Defined: misaligned half/word requests are rejected with resp_err.
//   Undefined: any alignment is accepted.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_RD   = 3'd1;
  localparam logic [2:0] LD_WAIT = 3'd2;
  localparam logic [2:0] RMW_RD  = 3'd3;
  localparam logic [2:0] RMW_MRG = 3'd4;
  localparam logic [2:0] ST_WR   = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;
  localparam logic [2:0] RESP    = 3'd7;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  logic [2:0]        r_state,        w_state_nxt;
  logic [1:0]        r_size,         w_size_nxt;
  logic              r_unsigned,     w_unsigned_nxt;
  logic [31:0]       r_wdata,        w_wdata_nxt;
  logic              r_resp_valid,   w_resp_valid_nxt;
  logic              r_resp_err,     w_resp_err_nxt;
  logic [31:0]       r_resp_rdata,   w_resp_rdata_nxt;
  logic              r_mem_en,       w_mem_en_nxt;
  logic              r_mem_rw,       w_mem_rw_nxt;
  logic [ADDR_W-1:0] r_mem_addr,     w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata,    w_mem_wdata_nxt;

  logic        w_accept;
  logic        w_misalign;
  logic        w_reject;
  logic [31:0] w_ext;
  logic [31:0] w_merged;

  // Ready is a decode of the state register, forced low while reset is held.
  assign req_ready  = (r_state == IDLE) && reset;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_en     = r_mem_en;
  assign mem_rw     = r_mem_rw;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  assign w_accept = req_valid && req_ready;

`ifdef ALIGN_CHECK_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = (req_size == 2'b11) || (req_addr > MAX_ADDR) || w_misalign;

  // Narrow and extend the read word according to the latched size/sign.
  always_comb begin
    w_ext = mem_rdata;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'd0, mem_rdata[7:0]}
                                  : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   w_ext = r_unsigned ? {16'd0, mem_rdata[15:0]}
                                  : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // Overlay the store bytes on the word read back from memory.
  always_comb begin
    w_merged = r_wdata;
    case (r_size)
      2'b00:   w_merged = {mem_rdata[31:8],  r_wdata[7:0]};
      2'b01:   w_merged = {mem_rdata[31:16], r_wdata[15:0]};
      default: w_merged = r_wdata;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_size_nxt       = r_size;
    w_unsigned_nxt   = r_unsigned;
    w_wdata_nxt      = r_wdata;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_err_nxt   = r_resp_err;
    w_resp_rdata_nxt = r_resp_rdata;
    w_mem_en_nxt     = 1'b0;
    w_mem_rw_nxt     = r_mem_rw;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_size_nxt       = req_size;
          w_unsigned_nxt   = req_unsigned;
          w_wdata_nxt      = req_wdata;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = 32'd0;
          if (w_reject) begin
            w_state_nxt = ERR;
          end else if (!req_we) begin
            w_state_nxt    = LD_RD;
            w_mem_en_nxt   = 1'b1;
            w_mem_rw_nxt   = 1'b0;
            w_mem_addr_nxt = req_addr;
          end else if (req_size == 2'b10) begin
            w_state_nxt     = ST_WR;
            w_mem_en_nxt    = 1'b1;
            w_mem_rw_nxt    = 1'b1;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_wdata;
          end else begin
            w_state_nxt    = RMW_RD;
            w_mem_en_nxt   = 1'b1;
            w_mem_rw_nxt   = 1'b0;
            w_mem_addr_nxt = req_addr;
          end
        end
      end
      LD_RD:   w_state_nxt = LD_WAIT;
      LD_WAIT: begin
        w_resp_rdata_nxt = w_ext;
        w_state_nxt      = RESP;
      end
      RMW_RD:  w_state_nxt = RMW_MRG;
      RMW_MRG: begin
        w_mem_en_nxt    = 1'b1;
        w_mem_rw_nxt    = 1'b1;
        w_mem_wdata_nxt = w_merged;
        w_state_nxt     = ST_WR;
      end
      ST_WR:   w_state_nxt = RESP;
      ERR: begin
        // Error responses arrive in RESP already presented.
        w_resp_err_nxt   = 1'b1;
        w_resp_rdata_nxt = 32'd0;
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = RESP;
      end
      RESP: begin
        // Memory-path responses are presented one cycle after entering RESP.
        if (!r_resp_valid) begin
          w_resp_valid_nxt = 1'b1;
        end else if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_en     <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_size       <= w_size_nxt;
      r_unsigned   <= w_unsigned_nxt;
      r_wdata      <= w_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_rw     <= w_mem_rw_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed requests against a byte-array
// memory model; expected responses go to a scoreboard queue popped by a
// monitor on each response handshake.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = 10'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;
  exp_t sb_q[$];
  int   next_id = 0;

  logic [7:0]  mem [0:1023];
  int          n_reads  = 0;
  int          n_writes = 0;
  logic [9:0]  last_wr_addr = 10'd0;
  logic [31:0] last_wr_data = 32'd0;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Memory model: 4 consecutive little-endian bytes, registered read data.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    {mem[7], mem[6], mem[5], mem[4]}         = 32'h99127254;
    {mem[11], mem[10], mem[9], mem[8]}       = 32'h12345678;
    {mem[1023], mem[1022], mem[1021], mem[1020]} = 32'h0BADF00D;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_rw) begin
          mem[int'(mem_addr)]   <= mem_wdata[7:0];
          mem[int'(mem_addr)+1] <= mem_wdata[15:8];
          mem[int'(mem_addr)+2] <= mem_wdata[23:16];
          mem[int'(mem_addr)+3] <= mem_wdata[31:24];
          n_writes     <= n_writes + 1;
          last_wr_addr <= mem_addr;
          last_wr_data <= mem_wdata;
        end else begin
          mem_rdata <= mem_word(int'(mem_addr));
          n_reads   <= n_reads + 1;
        end
      end
    end
  end

  // Monitor: compare each accepted response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("resp_rdata#%0d", e.id), resp_rdata, e.rdata);
          chk($sformatf("resp_err#%0d", e.id), {31'd0, resp_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Issue one request, check its latency, optionally stall the response.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int hold);
    int n;
    int lat;
    logic [31:0] saved;
    logic        saved_err;
    exp_t e;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    e.rdata = exp_rdata; e.err = exp_err; e.id = next_id;
    sb_q.push_back(e);
    next_id++;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    saved = resp_rdata;
    saved_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_rdata"}, resp_rdata, saved);
      chk({name, "_hold_ctl"}, {29'd0, resp_valid, resp_err, req_ready},
          {29'd0, 1'b1, saved_err, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int r0, w0;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp", {29'd0, resp_valid, resp_err, mem_en}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    do_req("ld_b_s_4",  1'b0, 2'b00, 1'b0, 10'd4, 32'd0, 32'h00000054, 1'b0, 3, 0);
    do_req("ld_b_s_7",  1'b0, 2'b00, 1'b0, 10'd7, 32'd0, 32'hFFFFFF99, 1'b0, 3, 0);
    do_req("ld_b_u_7",  1'b0, 2'b00, 1'b1, 10'd7, 32'd0, 32'h00000099, 1'b0, 3, 0);
    do_req("ld_h_u_6",  1'b0, 2'b01, 1'b1, 10'd6, 32'd0, 32'h00009912, 1'b0, 3, 0);
    do_req("ld_h_s_6",  1'b0, 2'b01, 1'b0, 10'd6, 32'd0, 32'hFFFF9912, 1'b0, 3, 0);
`ifdef ALIGN_CHECK_EN
    do_req("ld_h_s_5",  1'b0, 2'b01, 1'b0, 10'd5, 32'd0, 32'h00000000, 1'b1, 1, 0);
`else
    do_req("ld_h_s_5",  1'b0, 2'b01, 1'b0, 10'd5, 32'd0, 32'h00001272, 1'b0, 3, 0);
`endif

    r0 = n_reads; w0 = n_writes;
    do_req("st_b_8",    1'b1, 2'b00, 1'b0, 10'd8, 32'h000000AB, 32'd0, 1'b0, 4, 0);
    chk("st_b_8_reads",  32'(n_reads - r0), 32'd1);
    chk("st_b_8_writes", 32'(n_writes - w0), 32'd1);
    chk("st_b_8_wr_addr", {22'd0, last_wr_addr}, 32'd8);
    chk("st_b_8_wr_data", last_wr_data, 32'h123456AB);
    do_req("ld_w_8",    1'b0, 2'b10, 1'b0, 10'd8, 32'd0, 32'h123456AB, 1'b0, 3, 0);

    r0 = n_reads; w0 = n_writes;
    do_req("ld_w_1021", 1'b0, 2'b10, 1'b0, 10'd1021, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("st_sz11",   1'b1, 2'b11, 1'b0, 10'd8, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 0);
    do_req("ld_sz11",   1'b0, 2'b11, 1'b1, 10'd0, 32'd0, 32'd0, 1'b1, 1, 0);
    chk("err_no_mem_access", 32'(n_reads + n_writes - r0 - w0), 32'd0);

    do_req("ld_w_1020", 1'b0, 2'b10, 1'b0, 10'd1020, 32'd0, 32'h0BADF00D, 1'b0, 3, 0);
    do_req("st_w_12",   1'b1, 2'b10, 1'b0, 10'd12, 32'hDEADBEEF, 32'd0, 1'b0, 2, 0);
    do_req("ld_w_12",   1'b0, 2'b10, 1'b0, 10'd12, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0);
    do_req("st_h_12",   1'b1, 2'b01, 1'b0, 10'd12, 32'hFFFF1234, 32'd0, 1'b0, 4, 0);
    do_req("ld_w_12b",  1'b0, 2'b10, 1'b1, 10'd12, 32'd0, 32'hDEAD1234, 1'b0, 3, 0);
    do_req("ld_h_s_14", 1'b0, 2'b01, 1'b0, 10'd14, 32'd0, 32'hFFFFDEAD, 1'b0, 3, 0);
    do_req("ld_hold",   1'b0, 2'b00, 1'b1, 10'd4, 32'd0, 32'h00000054, 1'b0, 3, 3);

    // Reset asserted while the byte store sits in RMW_MRG.
    chk("rmw_rst_pre_ready", {31'd0, req_ready}, 32'd1);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 10'd8;
    req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    w0 = n_writes;
    #2 reset = 1'b0;
    #1;
    chk("rmw_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rmw_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rmw_rst_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmw_rst_no_write", 32'(n_writes - w0), 32'd0);
    chk("rmw_rst_word8", mem_word(8), 32'h123456AB);
    do_req("ld_w_8_post", 1'b0, 2'b10, 1'b0, 10'd8, 32'd0, 32'h123456AB, 1'b0, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
